// File: rtl/rp_ctrl_pkg.sv
// rp_ctrl_pkg: shared types and helpers for the reconfigurable-partition
// controller.
//   rp_state_e : sequencer states
//   cnt_w()    : width of a down-counter that can hold the largest of
//                three cycle counts
package rp_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DECOUPLE,
      LOAD,
      RESET_RM,
      COUPLE,
      ERROR
   } rp_state_e;

   function automatic int cnt_w(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/rp_cycle_counter.sv
// rp_cycle_counter: loadable down-counter with terminal-count flag.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (has priority over counting)
//   load_val  : value loaded on load
//   tc        : count has reached zero; the counter holds at zero
module rp_cycle_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (count != '0)
         count <= count - 1'b1;
   end

   assign tc = (count == '0);

endmodule

// File: rtl/rp_reconfig_ctrl.sv
// rp_reconfig_ctrl: sequences partial reconfiguration of one RP.
//   req_valid/req_ready/req_rm_id : load request from PS-side registers
//   pr_start/pr_rm_id             : command to the ZyCAP loader
//   pr_done/pr_error              : ZyCAP completion / failure pulses
//   decouple, rm_rst              : RP isolation and RM reset
//   rm_valid, rm_active_id        : currently running RM
//   busy, status_err, err_clr     : status and error acknowledge
// Sequence: IDLE -> DECOUPLE (settle) -> LOAD -> RESET_RM -> COUPLE -> IDLE,
// with LOAD falling into ERROR on pr_error or timeout.
module rp_reconfig_ctrl
   import rp_ctrl_pkg::*;
#(
   parameter int RM_ID_W        = 4,
   parameter int SETTLE_CYCLES  = 16,
   parameter int RM_RST_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 1048575
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [RM_ID_W-1:0] req_rm_id,
   output logic               pr_start,
   output logic [RM_ID_W-1:0] pr_rm_id,
   input  logic               pr_done,
   input  logic               pr_error,
   output logic               decouple,
   output logic               rm_rst,
   output logic               rm_valid,
   output logic [RM_ID_W-1:0] rm_active_id,
   output logic               busy,
   output logic               status_err,
   input  logic               err_clr
);

   localparam int CW = cnt_w(SETTLE_CYCLES, RM_RST_CYCLES, TIMEOUT_CYCLES);
   // Counter runs down to zero, so each phase loads its length minus one.
   localparam logic [CW-1:0] SETTLE_LD  = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] RM_RST_LD  = CW'(RM_RST_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LD = CW'(TIMEOUT_CYCLES - 1);

   rp_state_e     state_q, state_d;
   logic          cnt_load;
   logic [CW-1:0] cnt_val;
   logic          cnt_tc;
   logic          accept;

   assign accept = (state_q == IDLE) && req_valid;

   // One counter serves settle, load timeout and RM reset; the phases never
   // overlap and each one reloads it on entry.
   rp_cycle_counter #(.W(CW)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .tc       (cnt_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      cnt_load = 1'b0;
      cnt_val  = '0;
      case (state_q)
         IDLE: if (req_valid) begin
            state_d  = DECOUPLE;
            cnt_load = 1'b1;
            cnt_val  = SETTLE_LD;
         end
         DECOUPLE: if (cnt_tc) begin
            state_d  = LOAD;
            cnt_load = 1'b1;
            cnt_val  = TIMEOUT_LD;
         end
         LOAD: begin
            // Error beats done when both arrive together.
            if (pr_error) state_d = ERROR;
            else if (pr_done) begin
               state_d  = RESET_RM;
               cnt_load = 1'b1;
               cnt_val  = RM_RST_LD;
            end
            else if (cnt_tc) state_d = ERROR;
         end
         RESET_RM: if (cnt_tc) state_d = COUPLE;
         COUPLE:   state_d = IDLE;
         ERROR:    if (err_clr) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state
   // register. rm_rst stays low through DECOUPLE/LOAD so the old RM can drain;
   // the fresh RM sees exactly RM_RST_CYCLES of reset. IDLE keeps whatever the
   // previous exit left behind unless that exit was COUPLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_ready    <= 1'b1;
         pr_start     <= 1'b0;
         pr_rm_id     <= '0;
         decouple     <= 1'b1;
         rm_rst       <= 1'b1;
         rm_valid     <= 1'b0;
         rm_active_id <= '0;
         busy         <= 1'b0;
         status_err   <= 1'b0;
      end else begin
         req_ready  <= (state_d == IDLE);
         busy       <= !((state_d == IDLE) || (state_d == ERROR));
         status_err <= (state_d == ERROR);
         pr_start   <= (state_d == LOAD) && (state_q != LOAD);
         if (accept) pr_rm_id <= req_rm_id;
         case (state_d)
            DECOUPLE, LOAD, COUPLE: begin
               decouple <= 1'b1;
               rm_rst   <= 1'b0;
               rm_valid <= 1'b0;
            end
            RESET_RM, ERROR: begin
               decouple <= 1'b1;
               rm_rst   <= 1'b1;
               rm_valid <= 1'b0;
            end
            IDLE: if (state_q == COUPLE) begin
               decouple     <= 1'b0;
               rm_rst       <= 1'b0;
               rm_valid     <= 1'b1;
               rm_active_id <= pr_rm_id;
            end
            default: ;
         endcase
      end
   end

endmodule
